// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array feeder
//   max_int        : larger of two ints, used for the drain length L
//   feeder_state_e : RUN (idle/streaming) and DRAIN
//   lane_t         : one skew stage at the default operand width (data + valid)
package systolic_pkg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef enum logic {ST_RUN, ST_DRAIN} feeder_state_e;

  localparam int LANE_WIDTH = 8;

  typedef struct packed {
    logic [LANE_WIDTH-1:0] data;
    logic                  valid;
  } lane_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - operand stream in, skewed array edges out
//   in_valid_i/in_ready_o/in_last_i : beat handshake, last marks end of stream
//   in_west_i/in_north_i            : unskewed row/column operands
//   west_o/north_o (+ _valid_o)     : skewed lanes towards the array
//   done_o, beats_o                 : end-of-drain pulse, accepted beat count
//   master = operand source, slave = feeder
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 8,
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int CNT_W = 16
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic                      in_last_i;
  logic [ROW-1:0][WIDTH-1:0] in_west_i;
  logic [COL-1:0][WIDTH-1:0] in_north_i;
  logic [ROW-1:0][WIDTH-1:0] west_o;
  logic [COL-1:0][WIDTH-1:0] north_o;
  logic [ROW-1:0]            west_valid_o;
  logic [COL-1:0]            north_valid_o;
  logic                      done_o;
  logic [CNT_W-1:0]          beats_o;

  modport master (
    output in_valid_i, in_last_i, in_west_i, in_north_i,
    input  in_ready_o, west_o, north_o, west_valid_o, north_valid_o, done_o, beats_o
  );

  modport slave (
    input  in_valid_i, in_last_i, in_west_i, in_north_i,
    output in_ready_o, west_o, north_o, west_valid_o, north_valid_o, done_o, beats_o
  );
endinterface

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage reset-to-zero shift register of data+valid
//   clk_i, rstn_i     : clock, asynchronous active-low reset
//   data_i, valid_i   : stage 0 input, captured every cycle
//   data_o, valid_o   : last stage
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } stage_t;

  stage_t sr [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= '{data: data_i, valid: valid_i};
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign data_o  = sr[DEPTH-1].data;
  assign valid_o = sr[DEPTH-1].valid;

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - triangular-skew feeder for the west/north array edges
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus (slave)   : operand handshake in, skewed lanes, done pulse and beat count out
// West lane r is delayed r cycles, north lane c by c cycles; bubbles are zeros.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int CNT_W = 16
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  systolic_skew_feeder_if.slave  bus
);

  localparam int L    = max_int(ROW, COL);
  localparam int CW   = (L > 1) ? $clog2(L) : 1;

  feeder_state_e    state;
  logic [CW-1:0]    drain_cnt;
  logic [CNT_W-1:0] beats;
  logic             accept;

  // Ready is a pure state decode, so there is no path from in_valid_i.
  assign bus.in_ready_o = (state == ST_RUN);
  assign accept         = bus.in_valid_i && (state == ST_RUN);
  assign bus.done_o     = (state == ST_DRAIN) && (drain_cnt == '0);
  assign bus.beats_o    = beats;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      beats     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            beats <= beats + CNT_W'(1);
            if (bus.in_last_i) begin
              state     <= ST_DRAIN;
              drain_cnt <= CW'(L - 1);
            end
          end
        end
        ST_DRAIN: begin
          // Counter 0 is the cycle the last beat sits on the farthest lane.
          if (drain_cnt == '0) begin
            state <= ST_RUN;
            beats <= '0;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Lane 0 is the first register of each chain; it loads zero on a bubble
  // because the array never stalls.
  for (genvar r = 0; r < ROW; r++) begin : g_west
    logic [WIDTH-1:0] d_out;
    logic             v_out;
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(r + 1)) u_dl (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .data_i  (accept ? bus.in_west_i[r] : '0),
      .valid_i (accept),
      .data_o  (d_out),
      .valid_o (v_out)
    );
    assign bus.west_o[r]       = d_out;
    assign bus.west_valid_o[r] = v_out;
  end

  for (genvar c = 0; c < COL; c++) begin : g_north
    logic [WIDTH-1:0] d_out;
    logic             v_out;
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(c + 1)) u_dl (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .data_i  (accept ? bus.in_north_i[c] : '0),
      .valid_i (accept),
      .data_o  (d_out),
      .valid_o (v_out)
    );
    assign bus.north_o[c]       = d_out;
    assign bus.north_valid_o[c] = v_out;
  end

endmodule
